// File: rtl/systolic_array_ctrl_if.sv
// Handshake, operand-buffer and array-feed bundle for systolic_array_ctrl.
// The master modport is the sequencer's view. The slave modport is the host/buffer/array side.
interface systolic_array_ctrl_if #(
   parameter int N  = 256,
   parameter int M  = 256,
   parameter int KW = 9,
   parameter int DW = 32
);
   logic            start;
   logic [KW-1:0]   cfg_k;
   logic            busy;
   logic            done;
   logic            buf_rd_en;
   logic [KW-1:0]   buf_rd_addr;
   logic [N*DW-1:0] buf_a_data;
   logic [M*DW-1:0] buf_b_data;
   logic            arr_rst;
   logic [N*DW-1:0] feed_a;
   logic [M*DW-1:0] feed_b;
   logic [31:0]     perf_cycles;

   modport master (
      input  start, cfg_k, buf_a_data, buf_b_data,
      output busy, done, buf_rd_en, buf_rd_addr, arr_rst, feed_a, feed_b, perf_cycles
   );

   modport slave (
      output start, cfg_k, buf_a_data, buf_b_data,
      input  busy, done, buf_rd_en, buf_rd_addr, arr_rst, feed_a, feed_b, perf_cycles
   );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for one N x M systolic array: clear, skewed operand feed, drain, done pulse.
// Optional pass cycle counter is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_array_ctrl #(
   parameter int N    = 256,
   parameter int M    = 256,
   parameter int KMAX = 256,
   parameter int DW   = 32,
   parameter int KW   = $clog2(KMAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_array_ctrl_if.master bus
);
   localparam int CMAX = (KMAX > N + M) ? KMAX : N + M;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [KW-1:0] k_len_reg, k_len_next;
   logic          rd_vld_reg;
   logic [DW-1:0] feed_a_arr [N];
   logic [DW-1:0] feed_b_arr [M];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         k_len_reg  <= '0;
         rd_vld_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         k_len_reg  <= k_len_next;
         rd_vld_reg <= bus.buf_rd_en;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      k_len_next      = k_len_reg;
      bus.busy        = (state_reg != IDLE);
      bus.done        = (state_reg == DONE);
      bus.arr_rst     = (state_reg == CLEAR);
      bus.buf_rd_en   = (state_reg == FEED);
      bus.buf_rd_addr = (state_reg == FEED) ? KW'(cnt_reg) : '0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               k_len_next = (bus.cfg_k > KW'(KMAX)) ? KW'(KMAX) : bus.cfg_k;
               cnt_next   = '0;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            cnt_next   = '0;
            state_next = (k_len_reg != '0) ? FEED : DONE;
         end
         FEED: begin
            if (cnt_reg + CW'(1) == CW'(k_len_reg)) begin
               cnt_next   = '0;
               state_next = DRAIN;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DRAIN: begin
            // The drain window covers the longest skew line plus the array diagonal.
            if (cnt_reg == CW'(N + M - 2)) begin
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         logic [DW-1:0] head;
         assign head = rd_vld_reg ? bus.buf_a_data[gi*DW +: DW] : '0;
         if (gi == 0) begin : g_direct
            assign feed_a_arr[gi] = head;
         end else begin : g_line
            logic [DW-1:0] data_reg [gi];
            logic          vld_reg  [gi];
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int s = 0; s < gi; s++) begin
                     data_reg[s] <= '0;
                     vld_reg[s]  <= 1'b0;
                  end
               end else begin
                  data_reg[0] <= head;
                  vld_reg[0]  <= rd_vld_reg;
                  for (int s = 1; s < gi; s++) begin
                     data_reg[s] <= data_reg[s-1];
                     vld_reg[s]  <= vld_reg[s-1];
                  end
               end
            end
            assign feed_a_arr[gi] = vld_reg[gi-1] ? data_reg[gi-1] : '0;
         end
      end

      for (gi = 0; gi < M; gi++) begin : g_col
         logic [DW-1:0] head;
         assign head = rd_vld_reg ? bus.buf_b_data[gi*DW +: DW] : '0;
         if (gi == 0) begin : g_direct
            assign feed_b_arr[gi] = head;
         end else begin : g_line
            logic [DW-1:0] data_reg [gi];
            logic          vld_reg  [gi];
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int s = 0; s < gi; s++) begin
                     data_reg[s] <= '0;
                     vld_reg[s]  <= 1'b0;
                  end
               end else begin
                  data_reg[0] <= head;
                  vld_reg[0]  <= rd_vld_reg;
                  for (int s = 1; s < gi; s++) begin
                     data_reg[s] <= data_reg[s-1];
                     vld_reg[s]  <= vld_reg[s-1];
                  end
               end
            end
            assign feed_b_arr[gi] = vld_reg[gi-1] ? data_reg[gi-1] : '0;
         end
      end
   endgenerate

   always_comb begin
      bus.feed_a = '0;
      for (int i = 0; i < N; i++) bus.feed_a[i*DW +: DW] = feed_a_arr[i];
   end

   always_comb begin
      bus.feed_b = '0;
      for (int j = 0; j < M; j++) bus.feed_b[j*DW +: DW] = feed_b_arr[j];
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] perf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_reg <= '0;
      end else if (state_reg == IDLE && bus.start) begin
         perf_reg <= '0;
      end else if (state_reg != IDLE && perf_reg != '1) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end

   assign bus.perf_cycles = perf_reg;
`else
   assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl (N=M=2, KMAX=4): per-cycle timing model plus a
// wavefront product of the observed feeds checked against hand-computed C matrices.
module tb_systolic_array_ctrl;
   localparam int N = 2, M = 2, KMAX = 4, DW = 32, KW = 3;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 0;

   int unsigned a_mat [N][8];
   int unsigned b_mat [8][M];
   int unsigned fa_hist [N][64];
   int unsigned fb_hist [M][64];

   bit          m_active;
   int          m_t;
   int          m_k;
   logic [31:0] m_perf;

   systolic_array_ctrl_if #(.N(N), .M(M), .KW(KW), .DW(DW)) bus ();

   systolic_array_ctrl #(.N(N), .M(M), .KMAX(KMAX), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Operand SRAM: one-cycle registered read.
   always @(posedge clk) begin
      if (bus.buf_rd_en) begin
         bus.buf_a_data <= {a_mat[1][bus.buf_rd_addr], a_mat[0][bus.buf_rd_addr]};
         bus.buf_b_data <= {b_mat[bus.buf_rd_addr][1], b_mat[bus.buf_rd_addr][0]};
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pass model: a pass lasts L cycles after the accept edge.
   function automatic int pass_len(input int k);
      return (k > 0) ? k + N + M + 1 : 2;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_active <= 0;
         m_t      <= 0;
         m_perf   <= '0;
      end else if (m_active) begin
         if (m_perf != '1) m_perf <= m_perf + 32'd1;
         if (m_t == pass_len(m_k)) m_active <= 0;
         else m_t <= m_t + 1;
      end else if (bus.start) begin
         m_active <= 1;
         m_t      <= 1;
         m_k      <= (int'(bus.cfg_k) > KMAX) ? KMAX : int'(bus.cfg_k);
         m_perf   <= '0;
      end
   end

   always @(negedge clk) begin
      logic [63:0] ea, eb;
      bit          erd;
      int          idx;
      if (chk_en) begin
         ea = '0;
         eb = '0;
         erd = m_active && m_k > 0 && m_t >= 2 && m_t <= m_k + 1;
         if (m_active) begin
            for (int i = 0; i < N; i++) begin
               idx = m_t - 3 - i;
               if (idx >= 0 && idx < m_k) ea[i*DW +: DW] = a_mat[i][idx];
            end
            for (int j = 0; j < M; j++) begin
               idx = m_t - 3 - j;
               if (idx >= 0 && idx < m_k) eb[j*DW +: DW] = b_mat[idx][j];
            end
         end
         check("busy", bus.busy, m_active);
         check("done", bus.done, m_active && m_t == pass_len(m_k));
         check("arr_rst", bus.arr_rst, m_active && m_t == 1);
         check("buf_rd_en", bus.buf_rd_en, erd);
         check("buf_rd_addr", bus.buf_rd_addr, erd ? m_t - 2 : 0);
         check("feed_a", bus.feed_a, ea);
         check("feed_b", bus.feed_b, eb);
`ifdef SYSTOLIC_CTRL_PERF_EN
         check("perf_cycles", bus.perf_cycles, m_perf);
`else
         check("perf_cycles", bus.perf_cycles, 0);
`endif
      end
   end

   task automatic set_mats(input int sel);
      for (int k = 0; k < 8; k++) begin
         a_mat[0][k] = 99; a_mat[1][k] = 99; b_mat[k][0] = 99; b_mat[k][1] = 99;
      end
      if (sel == 0) begin
         a_mat[0][0] = 1; a_mat[0][1] = 2; a_mat[0][2] = 3;
         a_mat[1][0] = 4; a_mat[1][1] = 5; a_mat[1][2] = 6;
         b_mat[0][0] = 7;  b_mat[0][1] = 8;
         b_mat[1][0] = 9;  b_mat[1][1] = 10;
         b_mat[2][0] = 11; b_mat[2][1] = 12;
      end else begin
         for (int k = 0; k < 4; k++) begin
            a_mat[0][k] = k + 1;
            a_mat[1][k] = k + 5;
         end
         b_mat[0][0] = 1; b_mat[0][1] = 0;
         b_mat[1][0] = 0; b_mat[1][1] = 1;
         b_mat[2][0] = 1; b_mat[2][1] = 1;
         b_mat[3][0] = 2; b_mat[3][1] = 3;
      end
   endtask

   // Array emulation: PE(i,j) sees row i delayed j hops and column j delayed i hops.
   function automatic int unsigned pe_sum(input int i, input int j);
      int unsigned acc = 0;
      for (int t = 0; t < 64; t++) begin
         if (t - j >= 0 && t - i >= 0) acc += fa_hist[i][t - j] * fb_hist[j][t - i];
      end
      return acc;
   endfunction

   task automatic run_pass(input int cfg, input int exp_lat, input bit gap, input bit poke,
                           input int unsigned c00, input int unsigned c01,
                           input int unsigned c10, input int unsigned c11);
      int n;
      if (gap) begin
         bus.start = 0;
         repeat (2) @(negedge clk);
      end
      for (int t = 0; t < 64; t++) begin
         fa_hist[0][t] = 0; fa_hist[1][t] = 0; fb_hist[0][t] = 0; fb_hist[1][t] = 0;
      end
      bus.start = 1;
      bus.cfg_k = KW'(cfg);
      @(posedge clk);
      @(negedge clk);
      n = 1;
      while (1) begin
         fa_hist[0][n] = bus.feed_a[31:0];  fa_hist[1][n] = bus.feed_a[63:32];
         fb_hist[0][n] = bus.feed_b[31:0];  fb_hist[1][n] = bus.feed_b[63:32];
         if (bus.done || n >= 40) break;
         bus.start = poke && n == 3;
         @(negedge clk);
         n++;
      end
      check("latency", n, exp_lat);
      check("c00", pe_sum(0, 0), c00);
      check("c01", pe_sum(0, 1), c01);
      check("c10", pe_sum(1, 0), c10);
      check("c11", pe_sum(1, 1), c11);
      $display("[TB] pass cfg_k=%0d latency=%0d C=[[%0d,%0d],[%0d,%0d]]", cfg, n,
               pe_sum(0, 0), pe_sum(0, 1), pe_sum(1, 0), pe_sum(1, 1));
      bus.start = poke;
   endtask

   initial begin
      int n;
      rst = 1;
      bus.start = 0;
      bus.cfg_k = '0;
      bus.buf_a_data = '0;
      bus.buf_b_data = '0;
      set_mats(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      check("rst_busy", bus.busy, 0);
      check("rst_rd_en", bus.buf_rd_en, 0);
      check("rst_feed_a", bus.feed_a, 0);
      check("rst_perf", bus.perf_cycles, 0);
      rst = 0;

      run_pass(3, 8, 1, 0, 58, 64, 139, 154);
      @(negedge clk);
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("perf_after_done", bus.perf_cycles, 8);
      repeat (3) @(negedge clk);
      check("perf_held", bus.perf_cycles, 8);
`else
      check("perf_after_done", bus.perf_cycles, 0);
`endif

      run_pass(0, 2, 1, 0, 0, 0, 0, 0);

      set_mats(1);
      run_pass(7, 9, 1, 0, 12, 17, 28, 37);

      set_mats(0);
      run_pass(3, 8, 1, 1, 58, 64, 139, 154);
      @(posedge clk);
      @(negedge clk);
      check("idle_after_done_start", bus.busy, 0);
      run_pass(3, 8, 0, 0, 58, 64, 139, 154);
      bus.start = 0;
      repeat (5) @(negedge clk);

      bus.start = 1;
      bus.cfg_k = 3;
      @(posedge clk);
      @(negedge clk);
      bus.start = 0;
      n = 1;
      while (n < 3) begin
         @(negedge clk);
         n++;
      end
      check("mid_feed_rd_en", bus.buf_rd_en, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_busy", bus.busy, 0);
      check("abort_rd_en", bus.buf_rd_en, 0);
      check("abort_feed_a", bus.feed_a, 0);
      check("abort_feed_b", bus.feed_b, 0);
      run_pass(3, 8, 1, 0, 58, 64, 139, 154);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
